// File: rtl/gather_dat_1_2_pkg.sv
// ----------------------------------------------------------------------------
// gather_dat_1_2_pkg : shared types/constants for the 1:2 beat packer
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package gather_dat_1_2_pkg;

  localparam int DEF_DW    = 128;
  localparam int ORDER_BIT = 0;
  localparam int CFG_W     = 8;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_e;

endpackage : gather_dat_1_2_pkg

`default_nettype wire

// File: rtl/gather_dat_1_2_if.sv
// ----------------------------------------------------------------------------
// gather_dat_1_2_if : valid/ready beat stream with burst-last flag
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface gather_dat_1_2_if #(
  parameter int W = 128
) ();

  logic [W-1:0] dat;
  logic         req;
  logic         last;
  logic         ack;

  modport master (output dat, output req, output last, input ack);
  modport slave  (input dat, input req, input last, output ack);

endinterface : gather_dat_1_2_if

`default_nettype wire

// File: rtl/gather_dat_1_2.sv
// ----------------------------------------------------------------------------
// gather_dat_1_2 : packs two DW-bit beats into one 2*DW-bit word (odd tail zero-padded)
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module gather_dat_1_2
  import gather_dat_1_2_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int CNTW = 16
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  gather_dat_1_2_if.slave         t_0,
  input  wire logic [CFG_W-1:0]   t_cfg_dat,
  output logic      [CFG_W-1:0]   mode,
  gather_dat_1_2_if.master        i_0,
  output logic      [CNTW-1:0]    i_cnt
);

  localparam logic [DW-1:0] ZERO_BEAT = '0;

  state_e          state_q, state_d;
  logic [DW-1:0]   hold_q,  hold_d;
  logic            order_q, order_d;
  logic [2*DW-1:0] out_q,   out_d;
  logic            last_q,  last_d;
  logic            ov_q,    ov_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;
  logic            free;
  logic            take;

  // Output slot can accept a new word if empty or being drained this cycle.
  assign free = !ov_q || i_0.ack;
  assign take = t_0.req && t_0.ack;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    order_d = order_q;
    out_d   = out_q;
    last_d  = last_q;
    ov_d    = ov_q;
    t_0.ack = 1'b0;

    if (ov_q && i_0.ack) begin
      ov_d = 1'b0;
    end

    unique case (state_q)
      ST_EMPTY: begin
        if (!t_0.last) begin
          t_0.ack = 1'b1;
          if (take) begin
            hold_d  = t_0.dat;
            order_d = t_cfg_dat[ORDER_BIT];
            state_d = ST_HALF;
          end
        end else begin
          t_0.ack = free;
          if (take) begin
            out_d  = t_cfg_dat[ORDER_BIT] ? {t_0.dat, ZERO_BEAT}
                                          : {ZERO_BEAT, t_0.dat};
            last_d = 1'b1;
            ov_d   = 1'b1;
          end
        end
      end
      ST_HALF: begin
        t_0.ack = free;
        if (take) begin
          out_d   = order_q ? {hold_q, t_0.dat} : {t_0.dat, hold_q};
          last_d  = t_0.last;
          ov_d    = 1'b1;
          state_d = ST_EMPTY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ov_q && i_0.ack) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      hold_q  <= '0;
      order_q <= 1'b0;
      out_q   <= '0;
      last_q  <= 1'b0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      order_q <= order_d;
      out_q   <= out_d;
      last_q  <= last_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

  assign i_0.dat  = out_q;
  assign i_0.req  = ov_q;
  assign i_0.last = last_q;
  assign i_cnt    = cnt_q;
  assign mode     = t_cfg_dat;

endmodule : gather_dat_1_2

`default_nettype wire
